// File: rtl/ocu_fm0_tx_if.sv
// Power-manager / IE-memory side signals of the FM0 backscatter transmitter.
interface ocu_fm0_tx_if;
  logic        ocu_en;
  logic        trext;
  logic [7:0]  tx_len;
  logic [15:0] tx_rd_data;
  logic        tx_rd_en;
  logic [3:0]  tx_rd_addr;
  logic        tx_out;
  logic        ocu_iereq;
  logic        ocu_done;

  // Power manager plus response-word memory drive the enable and read data.
  modport master (
    output ocu_en, trext, tx_len, tx_rd_data,
    input  tx_rd_en, tx_rd_addr, tx_out, ocu_iereq, ocu_done
  );

  // Transmitter side.
  modport slave (
    input  ocu_en, trext, tx_len, tx_rd_data,
    output tx_rd_en, tx_rd_addr, tx_out, ocu_iereq, ocu_done
  );
endinterface

// File: rtl/ocu_fm0_tx.sv
// GB 1K tag backscatter transmitter: pilot, preamble, FM0 data and
// end-of-signaling at one half-symbol per DOUB_BLF cycle.
module ocu_fm0_tx #(
  parameter int unsigned PREP_CYC     = 2,
  parameter int unsigned PILOT_BITS   = 12,
  parameter logic [11:0] PREAMBLE_PAT = 12'b1101_0010_0011
) (
  input  logic            DOUB_BLF,
  input  logic            rst_n,
  ocu_fm0_tx_if.slave     bus
);

  localparam int unsigned CNT_W  = 6;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned WORD_W = 16;

  localparam logic [CNT_W-1:0] PREP_LAST  = CNT_W'(PREP_CYC - 1);
  localparam logic [CNT_W-1:0] PILOT_LAST = CNT_W'(2 * PILOT_BITS - 1);
  localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(11);

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_PILOT, S_PRE, S_DATA, S_EOS, S_DONE, S_WAIT
  } state_t;

  state_t             state;
  logic               en_q;
  logic               trext_q;
  logic [LEN_W-1:0]   len_q;
  logic [CNT_W-1:0]   cnt;
  logic [LEN_W-1:0]   bit_cnt;
  logic               half;
  logic [WORD_W-1:0]  shreg;
  logic [WORD_W-1:0]  pref;
  logic               rd_q;

  logic [LEN_W-1:0]   nxt_bit_c;
  logic               word_end_c;
  logic               need_next_c;
  logic               abort_c;

  // Next-bit bookkeeping, prefetch decision and abort detection.
  always_comb begin
    nxt_bit_c   = bit_cnt + LEN_W'(1);
    word_end_c  = (bit_cnt[3:0] == 4'hF);
    need_next_c = (nxt_bit_c[3:0] == 4'd8) &&
                  ((9'({nxt_bit_c[7:4], 4'b0000}) + 9'd16) < 9'(len_q));
    abort_c     = !bus.ocu_en &&
                  (state inside {S_PREP, S_PILOT, S_PRE, S_DATA, S_EOS});
  end

  // Frame sequencer, FM0 encoder and word fetch, all outputs registered.
  always_ff @(posedge DOUB_BLF or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      en_q           <= 1'b0;
      trext_q        <= 1'b0;
      len_q          <= '0;
      cnt            <= '0;
      bit_cnt        <= '0;
      half           <= 1'b0;
      shreg          <= '0;
      pref           <= '0;
      rd_q           <= 1'b0;
      bus.tx_out     <= 1'b0;
      bus.ocu_iereq  <= 1'b0;
      bus.ocu_done   <= 1'b0;
      bus.tx_rd_en   <= 1'b0;
      bus.tx_rd_addr <= '0;
    end else begin
      en_q          <= bus.ocu_en;
      bus.ocu_iereq <= 1'b0;
      bus.ocu_done  <= 1'b0;
      bus.tx_rd_en  <= 1'b0;
      rd_q          <= bus.tx_rd_en;
      if (rd_q) pref <= bus.tx_rd_data;

      if (abort_c) begin
        state          <= S_IDLE;
        bus.tx_out     <= 1'b0;
        bus.tx_rd_addr <= '0;
        rd_q           <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            bus.tx_out <= 1'b0;
            if (bus.ocu_en && !en_q) begin
              trext_q        <= bus.trext;
              len_q          <= bus.tx_len;
              bus.ocu_iereq  <= 1'b1;
              bus.tx_rd_addr <= '0;
              cnt            <= '0;
              state          <= S_PREP;
              if ((PREP_CYC == 1) && (bus.tx_len != '0)) bus.tx_rd_en <= 1'b1;
            end
          end

          S_PREP: begin
            if (cnt == PREP_LAST) begin
              cnt <= '0;
              if (trext_q) begin
                state      <= S_PILOT;
                bus.tx_out <= 1'b1;
              end else begin
                state      <= S_PRE;
                bus.tx_out <= PREAMBLE_PAT[11];
                shreg      <= {PREAMBLE_PAT[10:0], 5'b00000};
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
              if ((cnt + CNT_W'(1) == PREP_LAST) && (len_q != '0)) bus.tx_rd_en <= 1'b1;
            end
          end

          S_PILOT: begin
            if (cnt == PILOT_LAST) begin
              cnt        <= '0;
              state      <= S_PRE;
              bus.tx_out <= PREAMBLE_PAT[11];
              shreg      <= {PREAMBLE_PAT[10:0], 5'b00000};
            end else begin
              cnt        <= cnt + CNT_W'(1);
              bus.tx_out <= ~bus.tx_out;
            end
          end

          S_PRE: begin
            if (cnt == PRE_LAST) begin
              cnt        <= '0;
              half       <= 1'b0;
              bus.tx_out <= ~bus.tx_out;
              if (len_q == '0) begin
                state <= S_EOS;
              end else begin
                state   <= S_DATA;
                bit_cnt <= '0;
                shreg   <= pref;
              end
            end else begin
              cnt        <= cnt + CNT_W'(1);
              bus.tx_out <= shreg[WORD_W-1];
              shreg      <= shreg << 1;
            end
          end

          S_DATA: begin
            if (!half) begin
              half <= 1'b1;
              if (!shreg[WORD_W-1]) bus.tx_out <= ~bus.tx_out;
            end else begin
              half       <= 1'b0;
              bus.tx_out <= ~bus.tx_out;
              if (nxt_bit_c == len_q) begin
                state <= S_EOS;
              end else begin
                bit_cnt <= nxt_bit_c;
                shreg   <= word_end_c ? pref : (shreg << 1);
                if (need_next_c) begin
                  bus.tx_rd_en   <= 1'b1;
                  bus.tx_rd_addr <= bus.tx_rd_addr + 4'd1;
                end
              end
            end
          end

          S_EOS: begin
            if (!half) begin
              half <= 1'b1;
            end else begin
              half         <= 1'b0;
              state        <= S_DONE;
              bus.tx_out   <= 1'b0;
              bus.ocu_done <= 1'b1;
            end
          end

          S_DONE: begin
            bus.tx_out <= 1'b0;
            state      <= S_WAIT;
          end

          S_WAIT: begin
            bus.tx_out <= 1'b0;
            if (!bus.ocu_en) state <= S_IDLE;
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ocu_fm0_tx.sv
// Randomized frame bench for ocu_fm0_tx against a frame-level FM0 model.
module tb_ocu_fm0_tx;

  logic DOUB_BLF;
  logic rst_n;
  ocu_fm0_tx_if bus ();

  ocu_fm0_tx dut (
    .DOUB_BLF (DOUB_BLF),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  int          n_checks = 0;
  int          n_errs   = 0;
  logic [15:0] mem [16];
  logic        exp_q [$];
  logic [3:0]  rd_q  [$];

  initial begin
    DOUB_BLF = 1'b0;
    forever #5 DOUB_BLF = ~DOUB_BLF;
  end

  // Response-word memory: data presented right after the strobe, held until the next one.
  always @(posedge DOUB_BLF) begin
    #1;
    if (bus.tx_rd_en === 1'b1) begin
      rd_q.push_back(bus.tx_rd_addr);
      bus.tx_rd_data = mem[bus.tx_rd_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Expected tx_out levels of a whole frame, straight from the FM0 rules.
  function automatic void build_exp(input bit tr, input int len);
    logic [11:0] pat;
    logic [15:0] w;
    logic        lvl;
    logic        b;
    pat = 12'b1101_0010_0011;
    exp_q.delete();
    lvl = 1'b0;
    if (tr) begin
      for (int k = 0; k < 12; k++) begin
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
      end
    end
    for (int j = 11; j >= 0; j--) begin
      exp_q.push_back(pat[j]);
      lvl = pat[j];
    end
    for (int n = 0; n < len; n++) begin
      w   = mem[n / 16];
      b   = w[15 - (n % 16)];
      lvl = ~lvl;
      exp_q.push_back(lvl);
      if (!b) lvl = ~lvl;
      exp_q.push_back(lvl);
    end
    lvl = ~lvl;
    exp_q.push_back(lvl);
    exp_q.push_back(lvl);
  endfunction

  // One frame: start, PREP_CYC=2 wait, frame levels, done pulse, read strobes.
  task automatic run_frame(input bit tr, input int len, input bit raise, input int stop);
    int f;
    int last;
    logic e;
    build_exp(tr, len);
    rd_q.delete();
    bus.trext  = tr;
    bus.tx_len = 8'(len);
    if (raise) bus.ocu_en = 1'b1;
    f    = exp_q.size();
    last = 2 + f;
    for (int i = 0; i <= last; i++) begin
      @(posedge DOUB_BLF);
      #1;
      if (i == 0) begin
        bus.trext  = 1'($urandom);
        bus.tx_len = 8'($urandom);
      end
      e = (i >= 2 && i < last) ? exp_q[i-2] : 1'b0;
      chk("tx_out", 32'(bus.tx_out), 32'(e));
      chk("ocu_iereq", 32'(bus.ocu_iereq), 32'(i == 0));
      chk("ocu_done", 32'(bus.ocu_done), 32'(i == last));
      if (i == stop) return;
    end
    chk("rd_count", 32'(rd_q.size()), 32'((len + 15) / 16));
    for (int k = 0; k < rd_q.size(); k++) chk("rd_addr", 32'(rd_q[k]), 32'(k));
    bus.ocu_en = 1'b0;
    repeat (2) begin
      @(posedge DOUB_BLF);
      #1;
    end
    chk("idle_tx_out", 32'(bus.tx_out), 32'h0);
    chk("idle_done", 32'(bus.ocu_done), 32'h0);
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 16; k++) mem[k] = 16'($urandom);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.ocu_en     = 1'b0;
    bus.trext      = 1'b0;
    bus.tx_len     = 8'd0;
    bus.tx_rd_data = 16'h0;
    for (int k = 0; k < 16; k++) mem[k] = 16'h0;
    #12;
    chk("rst_tx_out", 32'(bus.tx_out), 32'h0);
    chk("rst_iereq", 32'(bus.ocu_iereq), 32'h0);
    chk("rst_done", 32'(bus.ocu_done), 32'h0);
    chk("rst_rd_en", 32'(bus.tx_rd_en), 32'h0);
    chk("rst_rd_addr", 32'(bus.tx_rd_addr), 32'h0);
    @(posedge DOUB_BLF);
    #1;
    rst_n = 1'b1;
    @(posedge DOUB_BLF);
    #1;

    // Basic frame
    mem[0] = 16'hA000;
    run_frame(1'b0, 4, 1'b1, -1);
    // Pilot
    mem[0] = 16'h8000;
    run_frame(1'b1, 1, 1'b1, -1);
    // Multi-word
    mem[0] = 16'hFFFF; mem[1] = 16'h0000; mem[2] = 16'hAAAA;
    run_frame(1'b0, 40, 1'b1, -1);
    // Empty payload
    run_frame(1'b0, 0, 1'b1, -1);
    // Exactly one word, and the longest frame
    fill_rand();
    run_frame(1'b1, 16, 1'b1, -1);
    fill_rand();
    run_frame(1'b1, 255, 1'b1, -1);

    // Random frames
    for (int r = 0; r < 8; r++) begin
      fill_rand();
      run_frame(1'($urandom), int'($urandom_range(0, 255)), 1'b1, -1);
    end

    // Abort during bit 10 of a 32-bit frame, then restart
    fill_rand();
    run_frame(1'b0, 32, 1'b1, 2 + 12 + 20);
    bus.ocu_en = 1'b0;
    @(posedge DOUB_BLF);
    #1;
    chk("abort_tx_out", 32'(bus.tx_out), 32'h0);
    chk("abort_done", 32'(bus.ocu_done), 32'h0);
    repeat (4) begin
      @(posedge DOUB_BLF);
      #1;
      chk("abort_quiet_done", 32'(bus.ocu_done), 32'h0);
      chk("abort_quiet_tx", 32'(bus.tx_out), 32'h0);
    end
    run_frame(1'b0, 32, 1'b1, -1);

    // Reset mid-data with ocu_en held high
    fill_rand();
    run_frame(1'b0, 64, 1'b1, 2 + 12 + 20);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_out", 32'(bus.tx_out), 32'h0);
    chk("mid_rst_iereq", 32'(bus.ocu_iereq), 32'h0);
    chk("mid_rst_done", 32'(bus.ocu_done), 32'h0);
    chk("mid_rst_rd_en", 32'(bus.tx_rd_en), 32'h0);
    chk("mid_rst_rd_addr", 32'(bus.tx_rd_addr), 32'h0);
    @(posedge DOUB_BLF);
    #1;
    rst_n = 1'b1;
    run_frame(1'b0, 64, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/ocu_fm0_tx.md
Name: ocu_fm0_tx

Overview:
- Tag-side backscatter transmitter (OCU) for the GB 1K RFID tag.
- It is the responder end of the power-manager enable/done handshake. It starts when the power manager raises ocu_en.
- On start it requests the IE data path, fetches the response words, and FM0-encodes pilot, preamble, data and end-of-signaling onto tx_out at half-symbol rate (one DOUB_BLF cycle per half-symbol).
- When the frame is finished it returns ocu_done, which sends the power manager back to receive.

Parameters:
- PREP_CYC, 2, DOUB_BLF cycles waited after the ocu_iereq pulse before the first word read (IE wake-up time).
- PILOT_BITS, 12, number of FM0 data-0 bits sent as pilot tone when trext=1.
- PREAMBLE_PAT, 12'b1101_0010_0011, absolute tx_out levels for the 12 preamble half-symbols, MSB first; contains the FM0 violation.

Ports:
- DOUB_BLF  in  1  single clock, 2x BLF; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- ocu_en  in  1  level enable from the power manager; high for the whole transmit phase.
- trext  in  1  pilot enable, sampled at start.
- tx_len  in  8  number of response data bits (0..255), sampled at start.
- tx_rd_data  in  16  response word; valid the cycle after tx_rd_en.
- tx_rd_en  out  1  one-cycle read strobe.
- tx_rd_addr  out  4  word address; 0 for the first word, incremented per read.
- tx_out  out  1  backscatter modulator level.
- ocu_iereq  out  1  one-cycle pulse requesting the IE path.
- ocu_done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset: tx_out=0, ocu_iereq=0, ocu_done=0, tx_rd_en=0, tx_rd_addr=0, state=IDLE. Reset mid-frame aborts immediately.
- IDLE: tx_out=0. A rising edge of ocu_en (previous registered ocu_en=0, current=1) does all of the following in the same cycle:
  - latch trext and tx_len;
  - pulse ocu_iereq;
  - go to PREP.
- ocu_en already high out of reset counts as a rising edge on the first clock.
- PREP: wait PREP_CYC cycles. On the last PREP cycle, pulse tx_rd_en with addr 0 if tx_len!=0.
- PREP exit: go to PILOT if trext=1, else to PRE.
- PILOT: 2*PILOT_BITS half-symbols of FM0 data-0, starting from phase level 0, so the output is 1,0,1,0,...
- PRE: emit PREAMBLE_PAT bits MSB first, one per cycle. The FM0 phase register takes the last emitted level (1).
- Next-word prefetch: load the prefetched word into a 16-bit shift register on the first DATA cycle. Issue the next tx_rd_en when 8 bits of the current word remain; the read data is held in a prefetch register.
- DATA: send tx_len bits, MSB of each word first.
  - Each bit takes 2 cycles.
  - First half-symbol = inverted phase.
  - Second half-symbol = same level for data-1, inverted again for data-0.
  - Phase register = second half level.
- DATA exit: after bit tx_len go to EOS. tx_len=0 skips DATA and goes straight to EOS, with no reads issued.
- EOS: one FM0 data-1 dummy bit (2 cycles).
- DONE: tx_out=0, one-cycle ocu_done pulse, then go to WAIT.
- WAIT: wait for ocu_en=0, then go to IDLE. A new transmission needs a fresh rising edge of ocu_en.
- Abort: ocu_en low in any state except IDLE, DONE or WAIT gives the following on the next cycle:
  - IDLE, with tx_out=0;
  - no ocu_done;
  - any pending read discarded;
  - tx_rd_addr cleared.
- tx_rd_addr:
  - wraps 15 to 0 (the tx_len cap of 255 bits needs at most 16 words);
  - no tx_rd_en is issued beyond the word containing bit tx_len.
- All outputs are registered; no combinational path from inputs to tx_out.
- Frame length in cycles = 24*trext + 12 + 2*tx_len + 2; ocu_done follows in the cycle after.

Test Plan:
- Basic frame: trext=0, tx_len=4, word0=16'hA000.
  - ocu_iereq at start cycle; one tx_rd_en, addr 0.
  - tx_out after preamble = 0,0,1,0,1,1,0,1,0,0.
  - ocu_done exactly 22 cycles after the first preamble half-symbol; then tx_out=0.
- Pilot: trext=1, tx_len=1, word0=16'h8000 -> 24 cycles of 1,0 alternation, then preamble 110100100011, then data 0,0, EOS 1,1, then ocu_done.
- Multi-word: tx_len=40, words 16'hFFFF, 16'h0000, 16'hAAAA.
  - Exactly 3 tx_rd_en strobes, at addr 0, 1 and 2.
  - Decoded bits match; no gap cycles at word boundaries.
- tx_len=0 -> no tx_rd_en; preamble then EOS (0,0); ocu_done 14 cycles after preamble start.
- Abort: drop ocu_en during bit 10 of a 32-bit frame.
  - Next cycle: tx_out=0, state IDLE, no ocu_done.
  - Re-raising ocu_en restarts with addr 0 and a new ocu_iereq.
- Reset: assert rst_n low mid-DATA -> all outputs 0 immediately; ocu_en held high through release -> one ocu_iereq and a full frame.
